stage_m_lsu: RTL and testbench

Parametrised memory stage for the combined ARM/RISC-V pipeline: EX/MEM pipeline register with stall and flush, plus a load/store unit that drives an external data-memory bus with a request/grant/response handshake. It supports byte, halfword and word accesses, with doubleword accesses when XLEN=64, including sign/zero extension of loads. While an access is outstanding it raises a busy signal to the hazard unit, which stalls the upstream stages. It sits between the execute stage and writeback and replaces the fixed-latency single-cycle data RAM.

---
 rtl/lsu_pkg.sv | 13 +
 rtl/lsu_align.sv | 44 ++++
 rtl/stage_m_lsu.sv | 164 ++++++++++++++++
 tb/tb_stage_m_lsu.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the memory-stage load/store unit: access sizes, bus FSM states
// and the size decode helper.
package lsu_pkg;

  typedef enum logic [1:0] {BYTE, HALF, WORD, DWORD} mem_size_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_t;

  function automatic int size_bytes(input mem_size_t s);
    return 1 << s;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: byte enables, replicated store data,
// alignment/size legality and load lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  mem_size_t                 size,
  input  logic [XLEN-1:0]           wdata,
  input  logic [XLEN-1:0]           rdata,
  input  logic                      is_unsigned,
  input  logic                      access,
  output logic [XLEN/8-1:0]         be,
  output logic [XLEN-1:0]           wdata_rep,
  output logic [XLEN-1:0]           rdata_ext,
  output logic                      misalign
);

  localparam int NB = XLEN / 8;

  int              off_i;
  int              sb;
  int              nbits;
  logic [XLEN-1:0] shifted;
  logic            sign;

  always_comb begin
    off_i    = int'(off);
    sb       = size_bytes(size);
    misalign = access && ((sb > NB) || ((off_i & (sb - 1)) != 0));
    // Oversized accesses are flagged above; clamp so extraction stays in range.
    nbits    = (sb > NB) ? XLEN : 8 * sb;
    shifted  = rdata >> (8 * off_i);
    sign     = shifted[nbits-1] && !is_unsigned;
    for (int j = 0; j < XLEN; j++) rdata_ext[j] = (j < nbits) ? shifted[j] : sign;
  end

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign be[i]             = (i >= off_i) && (i < off_i + sb);
    assign wdata_rep[8*i +: 8] = wdata[8*(i % sb) +: 8];
  end

endmodule

// File: rtl/stage_m_lsu.sv
// Memory stage: EX/MEM pipeline register plus a load/store unit that runs the
// request/grant/response handshake on the data bus and stalls upstream while busy.
module stage_m_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              StallM,
  input  logic              FlushM,
  input  logic [XLEN-1:0]   ALUResultE,
  input  logic [XLEN-1:0]   WriteDataE,
  input  logic [XLEN-1:0]   PCPlus4E,
  input  logic [RW-1:0]     RdE,
  input  logic              PCSrcE,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              MemReadE,
  input  logic              MemUnsignedE,
  input  logic [1:0]        ResultSrcE,
  input  logic [1:0]        MemSizeE,
  output logic [XLEN-1:0]   ALUResultM,
  output logic [XLEN-1:0]   PCPlus4M,
  output logic [RW-1:0]     RdM,
  output logic              PCSrcM,
  output logic              RegWriteM,
  output logic [1:0]        ResultSrcM,
  output logic [XLEN-1:0]   ReadDataW,
  output logic              MemBusyM,
  output logic              MisalignM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN/8-1:0] dmem_be,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [XLEN-1:0]   WriteData,
  output logic [XLEN-1:0]   DataAddr
);

  localparam int NB = XLEN / 8;

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] pc4;
    logic [RW-1:0]   rd;
    logic            pcsrc;
    logic            regwrite;
    logic            memwrite;
    logic            memread;
    logic            memuns;
    logic [1:0]      resultsrc;
    mem_size_t       size;
  } exmem_t;

  exmem_t          m_q, m_d, e_in;
  lsu_state_t      state_q, state_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            access, misalign, op, complete, busy, upd, in_wait;
  logic [NB-1:0]   be;
  logic [XLEN-1:0] wdata_rep, rdata_ext;

  // ISA mode has no consumer in this stage.
  logic unused_arm;
  assign unused_arm = arm;

  assign access  = m_q.memread | m_q.memwrite;
  assign in_wait = (state_q == WAIT);

  lsu_align #(.XLEN(XLEN)) u_align (
    .off        (m_q.alu[$clog2(NB)-1:0]),
    .size       (m_q.size),
    .wdata      (m_q.wdata),
    .rdata      (dmem_rdata),
    .is_unsigned(m_q.memuns),
    .access     (access),
    .be         (be),
    .wdata_rep  (wdata_rep),
    .rdata_ext  (rdata_ext),
    .misalign   (misalign)
  );

  assign op       = access & ~misalign & ~done_q;
  assign complete = in_wait ? dmem_rvalid : (op & dmem_gnt & m_q.memwrite);
  assign busy     = op & ~(m_q.memwrite & dmem_gnt) & ~(in_wait & dmem_rvalid);
  // Busy holds regardless of flush so the bus view stays stable mid-access.
  assign upd      = ~busy & (FlushM | ~StallM);

  always_comb begin
    e_in.alu       = ALUResultE;
    e_in.wdata     = WriteDataE;
    e_in.pc4       = PCPlus4E;
    e_in.rd        = RdE;
    e_in.pcsrc     = PCSrcE;
    e_in.regwrite  = RegWriteE;
    e_in.memwrite  = MemWriteE;
    e_in.memread   = MemReadE;
    e_in.memuns    = MemUnsignedE;
    e_in.resultsrc = ResultSrcE;
    e_in.size      = mem_size_t'(MemSizeE);

    m_d = m_q;
    if (upd) begin
      m_d = e_in;
      if (FlushM) begin
        m_d.pcsrc    = 1'b0;
        m_d.regwrite = 1'b0;
        m_d.memwrite = 1'b0;
        m_d.memread  = 1'b0;
      end
    end

    done_d  = upd ? 1'b0 : (done_q | complete);
    rdata_d = (in_wait && dmem_rvalid) ? rdata_ext : rdata_q;

    state_d = state_q;
    case (state_q)
      IDLE: if (op) state_d = !dmem_gnt ? REQ : (m_q.memwrite ? IDLE : WAIT);
      REQ:  if (dmem_gnt) state_d = m_q.memwrite ? IDLE : WAIT;
      WAIT: if (dmem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q     <= '0;
      state_q <= IDLE;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      m_q     <= m_d;
      state_q <= state_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign ALUResultM = m_q.alu;
  assign PCPlus4M   = m_q.pc4;
  assign RdM        = m_q.rd;
  assign PCSrcM     = m_q.pcsrc;
  assign RegWriteM  = m_q.regwrite;
  assign ResultSrcM = m_q.resultsrc;
  assign ReadDataW  = rdata_q;
  assign MemBusyM   = busy;
  assign MisalignM  = misalign;

  assign dmem_req   = op & ~in_wait;
  assign dmem_we    = dmem_req & m_q.memwrite;
  assign dmem_be    = dmem_req ? be : '0;
  assign dmem_addr  = m_q.alu;
  assign dmem_wdata = wdata_rep;
  assign WriteData  = wdata_rep;
  assign DataAddr   = m_q.alu;

endmodule

// File: tb/tb_stage_m_lsu.sv
// Directed bench for stage_m_lsu: stores, loads, grant stalls, misalignment,
// flush, stall-after-completion and reset in the middle of an access.
module tb_stage_m_lsu;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            arm, StallM, FlushM;
  logic [XLEN-1:0] ALUResultE, WriteDataE, PCPlus4E;
  logic [RW-1:0]   RdE;
  logic            PCSrcE, RegWriteE, MemWriteE, MemReadE, MemUnsignedE;
  logic [1:0]      ResultSrcE, MemSizeE;
  logic [XLEN-1:0] ALUResultM, PCPlus4M, ReadDataW;
  logic [RW-1:0]   RdM;
  logic            PCSrcM, RegWriteM, MemBusyM, MisalignM;
  logic [1:0]      ResultSrcM;
  logic            dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata, WriteData, DataAddr;
  logic [XLEN/8-1:0] dmem_be;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stage_m_lsu #(.XLEN(XLEN), .RW(RW)) dut (
    .clk(clk), .rst(rst), .arm(arm), .StallM(StallM), .FlushM(FlushM),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .MemReadE(MemReadE), .MemUnsignedE(MemUnsignedE), .ResultSrcE(ResultSrcE),
    .MemSizeE(MemSizeE), .ALUResultM(ALUResultM), .PCPlus4M(PCPlus4M), .RdM(RdM),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .ReadDataW(ReadDataW), .MemBusyM(MemBusyM), .MisalignM(MisalignM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .WriteData(WriteData), .DataAddr(DataAddr)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clr_e();
    ALUResultE = '0; WriteDataE = '0; PCPlus4E = '0; RdE = '0;
    PCSrcE = 0; RegWriteE = 0; MemWriteE = 0; MemReadE = 0; MemUnsignedE = 0;
    ResultSrcE = '0; MemSizeE = '0;
  endtask

  task automatic mem_e(input logic rd, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rdx);
    clr_e();
    MemReadE = rd; MemWriteE = ~rd; MemSizeE = sz; MemUnsignedE = uns;
    ALUResultE = addr; WriteDataE = wd; RdE = rdx; RegWriteE = rd;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 0; arm = 0; StallM = 0; FlushM = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
    clr_e();
    #3;
    chk("rst_req", dmem_req, 0);
    chk("rst_busy", MemBusyM, 0);
    chk("rst_rdata", ReadDataW, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_alu", ALUResultM, 0);
    @(negedge clk) rst = 1;

    // sb 0xAB at 0x1003, granted at once
    mem_e(0, 2'd0, 0, 32'h1003, 32'hAB, 0); dmem_gnt = 1;
    cyc(); clr_e(); #1;
    chk("sb_req", dmem_req, 1);
    chk("sb_we", dmem_we, 1);
    chk("sb_be", dmem_be, 4'b1000);
    chk("sb_wdata", dmem_wdata, 32'hABABABAB);
    chk("sb_busy", MemBusyM, 0);
    cyc(); #1;
    chk("sb_one_req", dmem_req, 0);

    // lh at 0x2002, gnt cycle 0, rvalid cycle 2
    mem_e(1, 2'd1, 0, 32'h2002, 0, 5); dmem_gnt = 1;
    cyc(); clr_e(); RdE = 7; RegWriteE = 1; #1;
    chk("lh_req", dmem_req, 1);
    chk("lh_we", dmem_we, 0);
    chk("lh_be", dmem_be, 4'b1100);
    chk("lh_busy0", MemBusyM, 1);
    cyc(); dmem_gnt = 0; #1;
    chk("lh_wait_req", dmem_req, 0);
    chk("lh_busy1", MemBusyM, 1);
    chk("lh_hold_rd", RdM, 5);
    cyc(); dmem_rvalid = 1; dmem_rdata = 32'h80010000; #1;
    chk("lh_busy2", MemBusyM, 0);
    cyc(); dmem_rvalid = 0; clr_e(); #1;
    chk("lh_data", ReadDataW, 32'hFFFF8001);
    chk("lh_next_rd", RdM, 7);

    // lhu, same data, rvalid in cycle 1
    mem_e(1, 2'd1, 1, 32'h2002, 0, 6); dmem_gnt = 1;
    cyc(); clr_e(); #1;
    chk("lhu_busy0", MemBusyM, 1);
    cyc(); dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h80010000; #1;
    chk("lhu_busy1", MemBusyM, 0);
    cyc(); dmem_rvalid = 0; #1;
    chk("lhu_data", ReadDataW, 32'h00008001);

    // lb at 0x3003; an rvalid in the request cycle must be ignored
    mem_e(1, 2'd0, 0, 32'h3003, 0, 8); dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'hFFFFFFFF;
    cyc(); clr_e(); #1;
    chk("lb_be", dmem_be, 4'b1000);
    chk("lb_ign_rvalid", MemBusyM, 1);
    cyc(); dmem_gnt = 0; dmem_rdata = 32'h7F000000; #1;
    cyc(); dmem_rvalid = 0; #1;
    chk("lb_data", ReadDataW, 32'h0000007F);

    // sw to 0x40, grant withheld three cycles
    mem_e(0, 2'd2, 0, 32'h40, 32'hDEADBEEF, 3);
    cyc(); clr_e(); RdE = 9; RegWriteE = 1;
    for (int c = 0; c < 4; c++) begin
      dmem_gnt = (c == 3); #1;
      chk("gs_req", dmem_req, 1);
      chk("gs_addr", dmem_addr, 32'h40);
      chk("gs_wdata", dmem_wdata, 32'hDEADBEEF);
      chk("gs_busy", MemBusyM, c != 3);
      chk("gs_hold_rd", RdM, 3);
      cyc();
    end
    dmem_gnt = 0; clr_e(); #1;
    chk("gs_done_req", dmem_req, 0);
    chk("gs_next_rd", RdM, 9);

    // zero-wait store completes under StallM: no re-request
    mem_e(0, 2'd2, 0, 32'h50, 32'h11, 0); dmem_gnt = 1;
    cyc(); StallM = 1; clr_e(); #1;
    chk("st_req", dmem_req, 1);
    chk("st_busy", MemBusyM, 0);
    cyc(); #1;
    chk("st_no_rereq", dmem_req, 0);
    chk("st_held_addr", dmem_addr, 32'h50);
    StallM = 0;
    cyc(); #1;
    chk("st_release", DataAddr, 0);

    // back-to-back stores
    mem_e(0, 2'd0, 0, 32'h10, 32'h5A, 0);
    cyc(); mem_e(0, 2'd1, 0, 32'h22, 32'h1234, 0); #1;
    chk("b2b_be0", dmem_be, 4'b0001);
    chk("b2b_wd0", dmem_wdata, 32'h5A5A5A5A);
    cyc(); clr_e(); #1;
    chk("b2b_req1", dmem_req, 1);
    chk("b2b_be1", dmem_be, 4'b1100);
    chk("b2b_wd1", dmem_wdata, 32'h12341234);
    chk("b2b_addr1", dmem_addr, 32'h22);
    cyc(); dmem_gnt = 0; #1;
    chk("b2b_idle", dmem_req, 0);

    // misaligned lw, then oversize dword on a 32-bit datapath
    mem_e(1, 2'd2, 0, 32'h102, 0, 1);
    cyc(); mem_e(1, 2'd3, 0, 32'h100, 0, 1); #1;
    chk("mis_lw", MisalignM, 1);
    chk("mis_lw_req", dmem_req, 0);
    chk("mis_lw_busy", MemBusyM, 0);
    cyc(); clr_e(); #1;
    chk("mis_ld", MisalignM, 1);
    chk("mis_ld_req", dmem_req, 0);
    cyc(); #1;
    chk("mis_clear", MisalignM, 0);

    // control pass-through, then a flushed load
    clr_e(); PCPlus4E = 32'h104; ResultSrcE = 2'd2; PCSrcE = 1; RegWriteE = 1; RdE = 12;
    cyc(); mem_e(1, 2'd2, 0, 32'h10, 0, 4); FlushM = 1; #1;
    chk("pt_pc4", PCPlus4M, 32'h104);
    chk("pt_rsrc", ResultSrcM, 2);
    chk("pt_pcsrc", PCSrcM, 1);
    chk("pt_rd", RdM, 12);
    cyc(); FlushM = 0; clr_e(); #1;
    chk("fl_regwrite", RegWriteM, 0);
    chk("fl_pcsrc", PCSrcM, 0);
    chk("fl_req", dmem_req, 0);

    // reset while waiting on a grant drops the request at once
    mem_e(1, 2'd2, 0, 32'h200, 0, 2);
    cyc(); clr_e(); #1;
    chk("rr_req", dmem_req, 1);
    rst = 0; #1;
    chk("rr_async_req", dmem_req, 0);
    #1 rst = 1;

    // reset in WAIT; a late rvalid afterwards is ignored
    mem_e(1, 2'd2, 0, 32'h204, 0, 2); dmem_gnt = 1;
    cyc(); clr_e(); dmem_gnt = 0; #1;
    chk("rw_busy0", MemBusyM, 1);
    cyc(); #1;
    chk("rw_wait_busy", MemBusyM, 1);
    rst = 0; #1;
    chk("rw_req", dmem_req, 0);
    chk("rw_rdata", ReadDataW, 0);
    chk("rw_busy", MemBusyM, 0);
    rst = 1; dmem_rvalid = 1; dmem_rdata = 32'h12345678;
    cyc(); dmem_rvalid = 0; #1;
    chk("rw_late_rvalid", ReadDataW, 0);
    chk("rw_idle_busy", MemBusyM, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
